// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first, idle-high line.
// Two-flop synchronizer, mid-bit sampling from a clocks-per-bit counter,
// registered one-cycle valid / frame_err strobes, held-low break handling.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   rx_meta_q, rx_s_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // FSM state, counters, shift register and registered output strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: half-bit start check, then full-bit spacing to mid-bit samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1 frames, LSB first, line idles high.
- Counterpart to the team's UART transmitter on the same serial link.
- Oversamples the line with a clocks-per-bit counter and samples each bit at mid-bit.
- Presents each received byte on a parallel bus with a one-cycle valid strobe, and flags framing errors.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and >= 4
DATA_BITS, 8, data bits per frame; width of data_out

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx  input  1  serial line, asynchronous to clk; idle = 1
data_out  output  DATA_BITS  last correctly framed byte; holds until the next good frame
valid  output  1  one-cycle pulse: data_out updated this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled as 0
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset (async) sets: state = IDLE, data_out = 0, valid = 0, frame_err = 0, both synchronizer FFs = 1, counters = 0, shift register = 0.
- Reset mid-frame abandons the frame silently; no valid or frame_err pulse follows.
- Synchronizer: rx passes through 2 flops to give rx_s. The FSM uses only rx_s.
- Definitions: H = CLKS_PER_BIT/2, C = CLKS_PER_BIT. Counter cnt is clog2(C) bits; bit index idx covers 0..DATA_BITS-1.
- IDLE: if rx_s == 0, go to START with cnt = 0. Otherwise stay.
- START: cnt increments each clk. At cnt == H-1, sample rx_s:
  - rx_s == 0: go to DATA, cnt = 0, idx = 0.
  - rx_s == 1: glitch; return to IDLE. No output pulse.
- DATA: cnt increments each clk. At cnt == C-1, sample rx_s:
  - Shift right with rx_s inserted at the MSB, so the first bit received ends up in bit 0.
  - Set cnt = 0 and increment idx.
  - After the sample taken at idx == DATA_BITS-1, go to STOP.
- STOP: at cnt == C-1, sample rx_s:
  - rx_s == 1: load data_out from the shift register, pulse valid, go to IDLE.
  - rx_s == 0: pulse frame_err, leave data_out unchanged, go to BREAK.
- BREAK: wait until rx_s == 1, then go to IDLE. A held-low line (break) never retriggers START.
- valid and frame_err are registered, never both high, and each lasts exactly 1 cycle.
- busy is combinational: (state != IDLE).
- Latency: let T0 be the clk edge at which the first synchronizer flop captures the falling start edge.
  - START is entered at edge T0+2; the start check is at T0+2+H.
  - Data bit k is sampled at T0+2+H+(k+1)·C.
  - The stop bit is sampled, and valid/frame_err are registered, at edge T0+2+H+(DATA_BITS+1)·C. For defaults this is T0+154.
- Back-to-back frames: a start bit directly following the stop bit is detected. IDLE is re-entered at the stop sample, and frames up to ±H/2 clk skew are tolerated.
- There is no receive buffer. A new byte overwrites data_out; the consumer must capture it on valid.

Test Plan:
- Reset then idle: hold rst 3 cycles with rx = 1 -> data_out = 0, valid = 0, frame_err = 0, busy = 0. Then rx = 1 for 200 cycles -> no pulses, busy stays 0.
- Single frame, defaults: send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) at 16 clk/bit -> valid pulses exactly once at T0+154 with data_out = 0xA5; busy high from T0+2 through T0+154.
- Back-to-back: frames 0x00, 0xFF, 0x3C sent with no idle gap -> three valid pulses 160 cycles apart, with data_out = 0x00, 0xFF, 0x3C in order; frame_err never asserts.
- Glitch rejection: drive rx low for 3 cycles then high -> FSM returns to IDLE at the start check; no valid; busy drops after H+3 cycles.
- Framing error / break:
  - Send 0x55 with the stop bit = 0, then hold rx low for 100 cycles, then high -> frame_err pulses once at T0+154; data_out keeps its prior value; busy stays high while rx is low.
  - A following good frame 0x12 -> valid with data_out = 0x12.
- Reset mid-frame and minimum parameter:
  - Assert rst during bit 4 of 0x81 -> outputs return to reset values immediately; no pulse follows. The next frame 0x81 is received correctly.
  - Repeat the single-frame scenario with CLKS_PER_BIT = 4 -> valid at T0+2+2+36 = T0+40.
